// File: rtl/multiplier_controller_taint_track.sv
// Shift-and-add multiplier controller (Moore FSM) with a sticky one-bit
// control-taint register that is reflected on every *_t output.
module multiplier_controller_taint_track #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             rsload,
  output logic             rsclear,
  output logic             rsshr,
  output logic             mrld,
  output logic             mdld,
  output logic             rsload_t,
  output logic             rsclear_t,
  output logic             rsshr_t,
  output logic             mrld_t,
  output logic             mdld_t,
  output logic             busy,
  output logic             done,
  output logic             done_t
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ctl_t_q, ctl_t_d;

  // State register: state, bit counter and taint move together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ctl_t_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_t_q <= ctl_t_d;
    end
  end

  // Next state. start/start_t only matter in IDLE; the multiplier bit and its
  // taint are only looked at in CHECK, so all other states ignore them.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_t_d = ctl_t_q;
    case (state_q)
      S_IDLE: begin
        if (start_t) ctl_t_d = 1'b1;
        if (start)   state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (multiplierReg_t[cnt_q]) ctl_t_d = 1'b1;
        state_d = multiplierReg[cnt_q] ? S_ADD : S_SHIFT;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_CHECK;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    rsload  = 1'b0;
    rsclear = 1'b0;
    rsshr   = 1'b0;
    mrld    = 1'b0;
    mdld    = 1'b0;
    done    = 1'b0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_LOAD: begin
        mrld    = 1'b1;
        mdld    = 1'b1;
        rsclear = 1'b1;
      end
      S_ADD:   rsload = 1'b1;
      S_SHIFT: rsshr  = 1'b1;
      S_DONE:  done   = 1'b1;
      default: ;
    endcase
  end

  // A single control-taint bit covers every strobe, busy and done.
  assign rsload_t  = ctl_t_q;
  assign rsclear_t = ctl_t_q;
  assign rsshr_t   = ctl_t_q;
  assign mrld_t    = ctl_t_q;
  assign mdld_t    = ctl_t_q;
  assign done_t    = ctl_t_q;

  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_LAST);
  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);
  a_taint_sticky: assert property (@(posedge clk) disable iff (rst) ctl_t_q |=> ctl_t_q);

endmodule

// File: doc/multiplier_controller_taint_track.md
MULTIPLIER_CONTROLLER_TAINT_TRACK -- requirements
Module: multiplier_controller_taint_track

Interface
REQ-001 Parameter: WIDTH, default 4, operand width; SHALL match the datapath's WIDTH and be >= 2.
REQ-002 Port list SHALL be, in order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new multiply.
- start_t  input  1  taint of start.
- multiplierReg  input  WIDTH  multiplier register value from the datapath.
- multiplierReg_t  input  WIDTH  per-bit taint of multiplierReg.
- rsload, rsclear, rsshr, mrld, mdld  output  1 each  datapath control strobes.
- rsload_t, rsclear_t, rsshr_t, mrld_t, mdld_t  output  1 each  taint of each strobe.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- done_t  output  1  taint of done and busy.
REQ-003 The block SHALL use one clock, clk, and a synchronous active-high reset, rst; it SHALL contain no other clocks and no asynchronous logic.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, CHECK, ADD, SHIFT and DONE, held in a state register.
REQ-005 Every output SHALL be decoded from registered state only (Moore); no output SHALL combinationally depend on start or multiplierReg.
REQ-006 Output decode SHALL be:
- LOAD: mrld=mdld=rsclear=1.
- ADD: rsload=1.
- SHIFT: rsshr=1.
- DONE: done=1.
- All strobes not listed for a state SHALL be 0.
REQ-007 IDLE SHALL go to LOAD when start=1; otherwise it SHALL stay in IDLE.
REQ-008 LOAD SHALL go to CHECK and SHALL clear the bit counter cnt to 0.
REQ-009 CHECK SHALL go to ADD if multiplierReg[cnt]=1, else to SHIFT.
REQ-010 ADD SHALL go to SHIFT.
REQ-011 SHIFT SHALL go to DONE when cnt=WIDTH-1.
REQ-012 Otherwise SHIFT SHALL increment cnt and go to CHECK.
REQ-013 DONE SHALL go to IDLE unconditionally; done SHALL be high for exactly one cycle.
REQ-014 cnt SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1 (no wrap-around).
REQ-015 Latency from the start-sampling edge to the done-high cycle SHALL be 1 + 2*WIDTH + popcount(multiplierReg) cycles.
REQ-016 start asserted in any state other than IDLE SHALL be ignored, with no effect on state, cnt or taint.
REQ-017 start held high through DONE SHALL start the next operation only after the FSM has returned to IDLE.
REQ-018 The taint register ctl_t (1 bit) SHALL be set when start_t=1 in IDLE, whether or not start=1.
REQ-019 ctl_t SHALL be set when multiplierReg_t[cnt]=1 in CHECK.
REQ-020 ctl_t SHALL be sticky and cleared only by rst.
REQ-021 Each *_t output SHALL equal ctl_t, registered alongside state, so the first tainted cycle is the cycle after the tainting sample.
REQ-022 Taint SHALL be conservative: an untainted bit SHALL never be reported tainted.

Reset
REQ-023 While rst=1 at a clock edge, the next state SHALL be IDLE, cnt=0 and ctl_t=0.
REQ-024 Reset SHALL take priority over all transitions, including mid-operation.
REQ-025 After reset, every output (strobes, *_t, busy, done, done_t) SHALL be 0.

Verification (WIDTH=4)
REQ-026 Reset check: assert rst for 2 cycles -> all outputs 0, state IDLE.
REQ-027 Clean multiply: multiplier 0b0101, start=1 one cycle, no taint ->
- state sequence LOAD,CHECK,ADD,SHIFT,CHECK,SHIFT,CHECK,ADD,SHIFT,CHECK,SHIFT,DONE;
- done on cycle 11 after the start edge;
- 2 rsload pulses and 4 rsshr pulses;
- all *_t outputs 0.
REQ-028 Tainted start: start=1, start_t=1 -> all *_t outputs 1 from the LOAD cycle through DONE and in IDLE afterwards, until rst.
REQ-029 Tainted bit: multiplierReg=0b1111, multiplierReg_t=0b0100 ->
- *_t outputs 0 through the bit-1 SHIFT;
- *_t outputs 1 from the bit-2 ADD onward;
- done_t=1;
- done on cycle 13.
REQ-030 start pulsed during ADD -> ignored, done timing unchanged.
REQ-031 rst asserted in ADD -> IDLE next cycle with all outputs 0.
REQ-032 Back-to-back: start held high continuously -> after the DONE cycle, one IDLE cycle, then LOAD.
